// File: rtl/noc_traffic_client_if.sv
// noc_traffic_client_if: credit-based multi-VC link between a traffic client and a switch leaf port
//   inj_vc_target  client->net  one-hot VC valid for inj_packet, all zero = idle
//   inj_packet     client->net  {dest[A_W-1:0], payload[D_W-1:0]}
//   inj_credit_gnt net->client  per-VC credit return, one pulse = one credit
//   ej_vc_target   net->client  one-hot VC valid for ej_packet
//   ej_packet      net->client  {dest[A_W-1:0], payload[D_W-1:0]}
//   ej_credit_gnt  client->net  per-VC credit return for ejected packets
interface noc_traffic_client_if #(
    parameter int A_W  = 2,
    parameter int D_W  = 32,
    parameter int VC_W = 2
);
    logic [VC_W-1:0]    inj_vc_target;
    logic [A_W+D_W-1:0] inj_packet;
    logic [VC_W-1:0]    inj_credit_gnt;
    logic [VC_W-1:0]    ej_vc_target;
    logic [A_W+D_W-1:0] ej_packet;
    logic [VC_W-1:0]    ej_credit_gnt;
    modport master (
        output inj_vc_target, inj_packet, ej_credit_gnt,
        input  inj_credit_gnt, ej_vc_target, ej_packet
    );
    modport slave (
        input  inj_vc_target, inj_packet, ej_credit_gnt,
        output inj_credit_gnt, ej_vc_target, ej_packet
    );
endinterface

// File: rtl/noc_traffic_client.sv
// noc_traffic_client: synthesizable NoC leaf traffic endpoint (random injection, checked ejection)
//   clk, rst_n        clock, asynchronous active-low reset
//   en                injection enable
//   rate              inject when lfsr[7:0] < rate
//   bp_rate           withhold ejection credits when lfsr[15:8] < bp_rate
//   limit             packets to send before draining (stable outside reset)
//   bus               master side of noc_traffic_client_if (injection + ejection links)
//   sent_cnt/recv_cnt packets injected / ejected, wrapping
//   err_cnt           saturating count of credit overflows and bad ejections
//   lat_max/lat_sum   latency statistics, zero unless NOC_TRAFFIC_CLIENT_LATENCY_EN is defined
//   done              high once drained after reaching limit
// Optional feature macro: NOC_TRAFFIC_CLIENT_LATENCY_EN (timestamped payloads + latency stats).
module noc_traffic_client #(
    parameter int          N             = 2,
    parameter int          A_W           = $clog2(N) + 1,
    parameter int          D_W           = 32,
    parameter int          VC_W          = 2,
    parameter int          VC_FIFO_DEPTH = 4,
    parameter int          POSX          = 0,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [7:0]           rate,
    input  logic [7:0]           bp_rate,
    input  logic [31:0]          limit,
    noc_traffic_client_if.master bus,
    output logic [31:0]          sent_cnt,
    output logic [31:0]          recv_cnt,
    output logic [15:0]          err_cnt,
    output logic [15:0]          lat_max,
    output logic [47:0]          lat_sum,
    output logic                 done
);
    localparam int            CW   = $clog2(VC_FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] CMAX = CW'(VC_FIFO_DEPTH - 1);
    localparam int            VW   = VC_W > 1 ? $clog2(VC_W) : 1;
    localparam int            PW   = A_W + D_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [31:0]              lfsr_q, lfsr_d;
    logic [VC_W-1:0][CW-1:0]  cred_q, cred_d;
    logic [VC_W-1:0][CW-1:0]  pend_q, pend_d;
    logic [VW-1:0]            last_q, last_d;
    logic [VC_W-1:0]          inj_vc_q, inj_vc_d;
    logic [PW-1:0]            pkt_q, pkt_d;
    logic [VC_W-1:0]          ejg_q, ejg_d;
    logic [31:0]              sent_q, sent_d;
    logic [31:0]              recv_q, recv_d;
    logic [15:0]              err_q, err_d;
    logic                     done_q, done_d;
    logic [VW-1:0]            pick, idx;
    logic                     found, fire, all_full, withhold, ej_any, ej_bad, snd, gnt;
    logic [A_W-1:0]           dest;
    logic [D_W-1:0]           payload;
    logic [15:0]              stamp;
    logic [7:0]               err_inc;
    logic [16:0]              err_sum;
    int                       dmod;

`ifdef NOC_TRAFFIC_CLIENT_LATENCY_EN
    logic [15:0] ts_q, ts_d, lat, lat_max_q, lat_max_d;
    logic [47:0] lat_sum_q, lat_sum_d;
    always_comb begin
        ts_d      = ts_q + 16'd1;
        lat       = ts_q - bus.ej_packet[15:0];
        lat_max_d = (ej_any && lat > lat_max_q) ? lat : lat_max_q;
        lat_sum_d = ej_any ? lat_sum_q + 48'(lat) : lat_sum_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            lat_max_q <= '0;
            lat_sum_q <= '0;
        end else begin
            ts_q      <= ts_d;
            lat_max_q <= lat_max_d;
            lat_sum_q <= lat_sum_d;
        end
    end
    assign stamp   = ts_q;
    assign lat_max = lat_max_q;
    assign lat_sum = lat_sum_q;
`else
    assign stamp   = lfsr_q[15:0];
    assign lat_max = '0;
    assign lat_sum = '0;
`endif

    always_comb begin
        lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
        pick     = last_q;
        idx      = '0;
        found    = 1'b0;
        // round-robin: first VC with credit, searching from the one after the last used
        for (int i = 1; i <= VC_W; i++) begin
            idx = VW'((int'(last_q) + i) % VC_W);
            if (!found && cred_q[idx] != '0) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        dmod     = int'(lfsr_q[31:16]) % N;
        dest     = A_W'(dmod == POSX ? (POSX + 1) % N : dmod);
        payload  = '0;
        payload[D_W-1 -: A_W] = A_W'(POSX);
        payload[15:0] = stamp;
        fire     = state_q == RUN && en && sent_q != limit && lfsr_q[7:0] < rate && found;
        inj_vc_d = fire ? VC_W'(1) << pick : '0;
        pkt_d    = fire ? {dest, payload} : pkt_q;
        last_d   = fire ? pick : last_q;
        sent_d   = sent_q + 32'(fire);
        err_inc  = '0;
        all_full = 1'b1;
        snd      = 1'b0;
        gnt      = 1'b0;
        for (int v = 0; v < VC_W; v++) begin
            snd       = fire && pick == VW'(v);
            gnt       = bus.inj_credit_gnt[v];
            cred_d[v] = cred_q[v];
            if (snd && !gnt)
                cred_d[v] = cred_q[v] - 1'b1;
            else if (!snd && gnt && cred_q[v] == CMAX)
                err_inc = err_inc + 8'd1;
            else if (!snd && gnt)
                cred_d[v] = cred_q[v] + 1'b1;
            all_full = all_full && cred_q[v] == CMAX;
        end
        ej_any   = |bus.ej_vc_target;
        // not one-hot: more than one bit set
        ej_bad   = ej_any && ((bus.ej_vc_target & (bus.ej_vc_target - 1'b1)) != '0
                   || bus.ej_packet[PW-1 -: A_W] != A_W'(POSX));
        err_inc  = err_inc + 8'(ej_bad);
        recv_d   = recv_q + 32'(ej_any);
        withhold = lfsr_q[15:8] < bp_rate;
        for (int v = 0; v < VC_W; v++) begin
            ejg_d[v]  = pend_q[v] != '0 && !withhold;
            pend_d[v] = pend_q[v];
            if (bus.ej_vc_target[v] && !ejg_d[v] && pend_q[v] == CMAX)
                err_inc = err_inc + 8'd1;
            else if (bus.ej_vc_target[v] && !ejg_d[v])
                pend_d[v] = pend_q[v] + 1'b1;
            else if (!bus.ej_vc_target[v] && ejg_d[v])
                pend_d[v] = pend_q[v] - 1'b1;
        end
        err_sum  = {1'b0, err_q} + 17'(err_inc);
        err_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        case (state_q)
            IDLE:    state_d = en ? RUN : IDLE;
            RUN:     state_d = sent_q == limit ? DRAIN : (en ? RUN : IDLE);
            DRAIN:   state_d = all_full ? DONE : DRAIN;
            default: state_d = DONE;
        endcase
        done_d   = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            cred_q   <= {VC_W{CMAX}};
            pend_q   <= '0;
            last_q   <= VW'(VC_W - 1);
            inj_vc_q <= '0;
            pkt_q    <= '0;
            ejg_q    <= '0;
            sent_q   <= '0;
            recv_q   <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cred_q   <= cred_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            inj_vc_q <= inj_vc_d;
            pkt_q    <= pkt_d;
            ejg_q    <= ejg_d;
            sent_q   <= sent_d;
            recv_q   <= recv_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign bus.inj_vc_target = inj_vc_q;
    assign bus.inj_packet    = pkt_q;
    assign bus.ej_credit_gnt = ejg_q;
    assign sent_cnt          = sent_q;
    assign recv_cnt          = recv_q;
    assign err_cnt           = err_q;
    assign done              = done_q;
endmodule

// File: doc/noc_traffic_client.md
Name: noc_traffic_client

Overview:
- Synthesizable, parametrised traffic endpoint for the NoC. It replaces the simulation-only client that sits on a switch's leaf ports in unit benches.
- Injection side: generates random-destination packets at a programmable rate over a credit-based, multi-VC link.
- Ejection side: sinks packets with programmable backpressure, checks the destination address and reports counters.
- Instantiated once per leaf on FPGA regression builds and in unit benches.

Parameters:
N, 2, number of clients; must be >= 2
A_W, $clog2(N)+1, address width
D_W, 32, payload width; must be >= A_W+16
VC_W, 2, number of virtual channels (one bit per VC)
VC_FIFO_DEPTH, 4, downstream FIFO depth; credits per VC = VC_FIFO_DEPTH-1
POSX, 0, this client's address, 0..N-1
LFSR_SEED, 32'hACE1_0001, nonzero seed for the 32-bit Galois LFSR (taps 32,22,2,1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  injection enable; sampled every cycle
rate  in  8  inject on a cycle when lfsr[7:0] < rate (0 = never, 255 = 255/256)
bp_rate  in  8  withhold ejection credit when lfsr[15:8] < bp_rate
limit  in  32  packets to send before draining; change only while rst_n=0
inj_vc_target  out  VC_W  one-hot VC valid for inj_packet; all zero = idle
inj_packet  out  A_W+D_W  {dest[A_W-1:0], payload[D_W-1:0]}
inj_credit_gnt  in  VC_W  per-VC credit return, one pulse = one credit
ej_vc_target  in  VC_W  one-hot incoming packet valid
ej_packet  in  A_W+D_W  incoming packet
ej_credit_gnt  out  VC_W  per-VC credit return to the network
sent_cnt  out  32  packets injected
recv_cnt  out  32  packets ejected
err_cnt  out  16  saturating error count
lat_max  out  16  maximum observed latency (optional feature)
lat_sum  out  48  accumulated latency (optional feature)
done  out  1  high in DONE state

Behaviour:
- Reset (rst_n=0, async): all outputs 0; FSM to IDLE; LFSR loaded with LFSR_SEED; every credit counter set to VC_FIFO_DEPTH-1; pending ejection credits cleared. Reset asserted mid-packet discards everything, with no partial state kept.
- The LFSR advances every cycle outside reset.
- FSM:
  - IDLE -> RUN when en=1.
  - RUN -> IDLE when en=0.
  - RUN -> DRAIN when sent_cnt == limit. limit=0 goes IDLE->RUN->DRAIN with no injection.
  - DRAIN -> DONE when every injection credit counter is back to VC_FIFO_DEPTH-1.
  - DONE holds until reset.
- Injection, registered output, one packet per cycle maximum, only in RUN:
  - Fires when the rate draw passes and at least one VC has credit > 0.
  - VC choice: round-robin over VCs with credit, starting after the last VC used.
  - Dest = lfsr[31:16] mod N; if dest == POSX, use (POSX+1) mod N.
  - Payload[D_W-1 -: A_W] = POSX; payload[15:0] = timestamp (feature on) or lfsr[15:0] (feature off); remaining bits 0.
  - inj_vc_target asserts for exactly that cycle; sent_cnt increments in the same cycle.
- Injection credit counters, width $clog2(VC_FIFO_DEPTH)+1:
  - Decrement on send, increment on inj_credit_gnt.
  - Send and grant on the same VC in the same cycle leaves the counter unchanged.
  - A grant while the counter is at maximum: counter saturates and err_cnt increments.
- Ejection: on any ej_vc_target bit, recv_cnt increments. If ej_vc_target is not one-hot, or ej_packet dest != POSX, err_cnt increments (once per cycle).
- Each accepted packet adds one pending credit on its VC (per-VC counter, maximum VC_FIFO_DEPTH-1). Overflow of that counter: saturate and increment err_cnt.
- Each cycle, for each VC with pending > 0 and a bp draw that does not withhold: ej_credit_gnt[v]=1 (registered) and pending decrements. At most one grant per VC per cycle. Arrival and grant on the same VC in the same cycle net to zero.
- err_cnt saturates at 16'hFFFF.
- sent_cnt and recv_cnt wrap modulo 2^32.

Optional Feature:
- Macro: NOC_TRAFFIC_CLIENT_LATENCY_EN.
- Defined:
  - A free-running 16-bit cycle counter (reset 0) is stamped into payload[15:0].
  - On ejection, latency = (now - stamp) mod 2^16.
  - lat_sum += latency, 48-bit wrap.
  - lat_max = max(lat_max, latency).
- Undefined: no timestamp counter; payload[15:0] = lfsr[15:0]; lat_max and lat_sum tied to 0.

Test Plan:
- Loopback, N=2, POSX=0, rate=255, bp_rate=0, limit=10, VC_FIFO_DEPTH=4, ej fed from a 1-cycle-delayed, re-addressed copy of inj -> sent_cnt=10; at most 3 outstanding per VC; done=1 after the final credits return; err_cnt=0.
- No credits returned, rate=255, VC_W=2 -> exactly 6 packets sent; then inj_vc_target stays 0; FSM stays in RUN; done=0.
- ej_packet dest=1 at POSX=0, plus a cycle with ej_vc_target=2'b11 -> err_cnt=2; recv_cnt=2.
- bp_rate=255 with 3 arrivals on VC0 -> ej_credit_gnt stays 0. Set bp_rate=0 -> three single-cycle pulses on ej_credit_gnt[0] in consecutive cycles.
- Assert rst_n low mid-run with sent_cnt=5 -> all outputs 0 asynchronously; after release, credits=3 per VC and injection restarts from the seed sequence.
- LATENCY_EN defined, fixed 7-cycle loopback, limit=4 -> lat_max=7, lat_sum=28.
